// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the pipeline hazard/halt controller.
// Optional perf counters (PIPE_PERF_CNT_EN) use sat_inc16.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

    localparam int DRAIN_CYCLES_DEF = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Purely combinational hazard compare: load-use against EX, and branch
// hazards on pending flags or on the register of a register-indirect branch.
module hazard_detect (
    input  logic [3:0] id_src1,
    input  logic [3:0] id_src2,
    input  logic       id_use1,
    input  logic       id_use2,
    input  logic       id_branch,
    input  logic       id_br,
    input  logic [3:0] ex_rd,
    input  logic       ex_reg_write,
    input  logic       ex_mem_to_reg,
    input  logic       ex_flag_wr,
    input  logic [3:0] mem_rd,
    input  logic       mem_mem_to_reg,
    output logic       load_use,
    output logic       br_hz
);

    logic src1_hit_ex;
    logic src2_hit_ex;
    logic br_reg_hz;

    // R0 is hardwired zero, so it never carries a dependency
    assign src1_hit_ex = id_use1 && (id_src1 == ex_rd);
    assign src2_hit_ex = id_use2 && (id_src2 == ex_rd);

    assign load_use = ex_mem_to_reg && (ex_rd != 4'd0) && (src1_hit_ex || src2_hit_ex);

    // BR target register must be final in ID: wait on any EX write or a MEM load
    assign br_reg_hz = (id_src1 != 4'd0) &&
                       (((id_src1 == ex_rd)  && ex_reg_write) ||
                        ((id_src1 == mem_rd) && mem_mem_to_reg));

    assign br_hz = id_branch && (id_br ? br_reg_hz : ex_flag_wr);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with HLT drain sequencing.
// Optional perf counters enabled by defining PIPE_PERF_CNT_EN.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ID_SrcReg1,
    input  logic [3:0] ID_SrcReg2,
    input  logic       ID_use1,
    input  logic       ID_use2,
    input  logic       ID_Branch,
    input  logic       ID_BR,
    input  logic       ID_Branch_taken,
    input  logic       ID_HLT,
    input  logic [3:0] ID_EX_reg_rd,
    input  logic       ID_EX_RegWrite,
    input  logic       ID_EX_MemToReg,
    input  logic       ID_EX_flag_wr,
    input  logic [3:0] EX_MEM_reg_rd,
    input  logic       EX_MEM_MemToReg,
    output logic       PC_stall,
    output logic       IF_ID_stall,
    output logic       IF_ID_flush,
    output logic       ID_EX_flush,
    output logic       halted
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic        cnt_en_n
`endif
);

    // state  | meaning
    // RUN    | normal issue; hazards stall, taken branches flush IF/ID
    // DRAIN  | HLT seen; fetch frozen while older instructions retire
    // HALTED | drain complete; frozen until reset

    localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    pipe_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;

    logic load_use;
    logic br_hz;
    logic hazard;

    logic pc_stall_c;
    logic if_id_stall_c;
    logic if_id_flush_c;
    logic id_ex_flush_c;

    hazard_detect u_hazard_detect (
        .id_src1        (ID_SrcReg1),
        .id_src2        (ID_SrcReg2),
        .id_use1        (ID_use1),
        .id_use2        (ID_use2),
        .id_branch      (ID_Branch),
        .id_br          (ID_BR),
        .ex_rd          (ID_EX_reg_rd),
        .ex_reg_write   (ID_EX_RegWrite),
        .ex_mem_to_reg  (ID_EX_MemToReg),
        .ex_flag_wr     (ID_EX_flag_wr),
        .mem_rd         (EX_MEM_reg_rd),
        .mem_mem_to_reg (EX_MEM_MemToReg),
        .load_use       (load_use),
        .br_hz          (br_hz)
    );

    assign hazard = load_use || br_hz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        halted_d      = halted_q;
        pc_stall_c    = 1'b0;
        if_id_stall_c = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        case (state_q)
            RUN: begin
                // an unresolved branch must not flush, so hazards win
                if (hazard) begin
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (ID_HLT) begin
                    pc_stall_c    = 1'b1;
                    if_id_flush_c = 1'b1;
                    cnt_d         = CNT_W'(DRAIN_CYCLES);
                    state_d       = DRAIN;
                end else if (ID_Branch_taken) begin
                    if_id_flush_c = 1'b1;
                end
            end
            DRAIN: begin
                pc_stall_c    = 1'b1;
                if_id_flush_c = 1'b1;
                if (cnt_q == '0) begin
                    state_d  = HALTED;
                    halted_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HALTED: begin
                pc_stall_c    = 1'b1;
                if_id_flush_c = 1'b1;
                halted_d      = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // held low while reset is asserted, whatever the ID inputs are doing
    assign PC_stall    = rst_n && pc_stall_c;
    assign IF_ID_stall = rst_n && if_id_stall_c;
    assign IF_ID_flush = rst_n && if_id_flush_c;
    assign ID_EX_flush = rst_n && id_ex_flush_c;
    assign halted      = halted_q;

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // only RUN cycles count, so both freeze through DRAIN and HALTED
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (state_q == RUN) begin
            if (hazard) begin
                stall_cnt_q <= sat_inc16(stall_cnt_q);
            end
            if (if_id_flush_c) begin
                flush_cnt_q <= sat_inc16(flush_cnt_q);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign cnt_en_n  = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (DRAIN_CYCLES = 4).
// Counter checks are compiled in when PIPE_PERF_CNT_EN is defined.
module tb_pipeline_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] ID_SrcReg1;
    logic [3:0] ID_SrcReg2;
    logic       ID_use1;
    logic       ID_use2;
    logic       ID_Branch;
    logic       ID_BR;
    logic       ID_Branch_taken;
    logic       ID_HLT;
    logic [3:0] ID_EX_reg_rd;
    logic       ID_EX_RegWrite;
    logic       ID_EX_MemToReg;
    logic       ID_EX_flag_wr;
    logic [3:0] EX_MEM_reg_rd;
    logic       EX_MEM_MemToReg;
    logic       PC_stall;
    logic       IF_ID_stall;
    logic       IF_ID_flush;
    logic       ID_EX_flush;
    logic       halted;
`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic        cnt_en_n;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_ctrl #(.DRAIN_CYCLES(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ID_SrcReg1      (ID_SrcReg1),
        .ID_SrcReg2      (ID_SrcReg2),
        .ID_use1         (ID_use1),
        .ID_use2         (ID_use2),
        .ID_Branch       (ID_Branch),
        .ID_BR           (ID_BR),
        .ID_Branch_taken (ID_Branch_taken),
        .ID_HLT          (ID_HLT),
        .ID_EX_reg_rd    (ID_EX_reg_rd),
        .ID_EX_RegWrite  (ID_EX_RegWrite),
        .ID_EX_MemToReg  (ID_EX_MemToReg),
        .ID_EX_flag_wr   (ID_EX_flag_wr),
        .EX_MEM_reg_rd   (EX_MEM_reg_rd),
        .EX_MEM_MemToReg (EX_MEM_MemToReg),
        .PC_stall        (PC_stall),
        .IF_ID_stall     (IF_ID_stall),
        .IF_ID_flush     (IF_ID_flush),
        .ID_EX_flush     (ID_EX_flush),
        .halted          (halted)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .cnt_en_n        (cnt_en_n)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        ID_SrcReg1      = 4'd0;
        ID_SrcReg2      = 4'd0;
        ID_use1         = 1'b0;
        ID_use2         = 1'b0;
        ID_Branch       = 1'b0;
        ID_BR           = 1'b0;
        ID_Branch_taken = 1'b0;
        ID_HLT          = 1'b0;
        ID_EX_reg_rd    = 4'd0;
        ID_EX_RegWrite  = 1'b0;
        ID_EX_MemToReg  = 1'b0;
        ID_EX_flag_wr   = 1'b0;
        EX_MEM_reg_rd   = 4'd0;
        EX_MEM_MemToReg = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stall_set(input string tag, input logic exp);
        #1;
        chk({tag, ".pc_stall"},    PC_stall,    exp);
        chk({tag, ".if_id_stall"}, IF_ID_stall, exp);
        chk({tag, ".id_ex_flush"}, ID_EX_flush, exp);
    endtask

    task automatic load_r3_read_r3();
        idle();
        ID_EX_MemToReg = 1'b1;
        ID_EX_RegWrite = 1'b1;
        ID_EX_reg_rd   = 4'd3;
        ID_use1        = 1'b1;
        ID_SrcReg1     = 4'd3;
    endtask

    initial begin
        // reset with hazard-provoking inputs: every combinational output low
        rst_n = 1'b0;
        load_r3_read_r3();
        ID_Branch_taken = 1'b1;
        #2;
        chk("rst.pc_stall",    PC_stall,    1'b0);
        chk("rst.if_id_stall", IF_ID_stall, 1'b0);
        chk("rst.id_ex_flush", ID_EX_flush, 1'b0);
        chk("rst.if_id_flush", IF_ID_flush, 1'b0);
        chk("rst.halted",      halted,      1'b0);
`ifdef PIPE_PERF_CNT_EN
        chk("rst.stall_cnt", stall_cnt, 16'd0);
        chk("rst.flush_cnt", flush_cnt, 16'd0);
        chk("rst.cnt_en_n",  cnt_en_n,  1'b0);
`endif
        tick();
        tick();
        idle();
        rst_n = 1'b1;
        tick();

        // load-use on R3 via src1: one stall cycle, then the bubble clears it
        load_r3_read_r3();
        stall_set("lu1", 1'b1);
        chk("lu1.if_id_flush", IF_ID_flush, 1'b0);
        tick();
        idle();
        ID_use1    = 1'b1;
        ID_SrcReg1 = 4'd3;
        stall_set("lu1_after", 1'b0);
        tick();

        // load-use via src2
        idle();
        ID_EX_MemToReg = 1'b1;
        ID_EX_reg_rd   = 4'd7;
        ID_use1        = 1'b1;
        ID_SrcReg1     = 4'd2;
        ID_use2        = 1'b1;
        ID_SrcReg2     = 4'd7;
        stall_set("lu2", 1'b1);
        tick();

        // matching registers that are not read
        ID_use1    = 1'b0;
        ID_use2    = 1'b0;
        ID_SrcReg1 = 4'd7;
        stall_set("lu_unused", 1'b0);
        tick();

        // load to R0 with ID reading R0
        idle();
        ID_EX_MemToReg = 1'b1;
        ID_EX_reg_rd   = 4'd0;
        ID_use1        = 1'b1;
        ID_use2        = 1'b1;
        stall_set("r0", 1'b0);
        tick();

        // ALU write (not a load) to a read register: forwarding, no stall
        idle();
        ID_EX_RegWrite = 1'b1;
        ID_EX_reg_rd   = 4'd3;
        ID_use1        = 1'b1;
        ID_SrcReg1     = 4'd3;
        stall_set("alu_dep", 1'b0);
        tick();

        // conditional taken branch behind a flag-setter: stall, then flush
        idle();
        ID_EX_flag_wr   = 1'b1;
        ID_Branch       = 1'b1;
        ID_Branch_taken = 1'b1;
        stall_set("br_c1", 1'b1);
        chk("br_c1.if_id_flush", IF_ID_flush, 1'b0);
        tick();
        ID_EX_flag_wr = 1'b0;
        stall_set("br_c2", 1'b0);
        chk("br_c2.if_id_flush", IF_ID_flush, 1'b1);
        tick();
        idle();
        #1;
        chk("br_c3.if_id_flush", IF_ID_flush, 1'b0);
        tick();

        // BR R5 with EX writing R5
        idle();
        ID_Branch       = 1'b1;
        ID_BR           = 1'b1;
        ID_SrcReg1      = 4'd5;
        ID_use1         = 1'b1;
        ID_Branch_taken = 1'b1;
        ID_EX_RegWrite  = 1'b1;
        ID_EX_reg_rd    = 4'd5;
        stall_set("brx", 1'b1);
        chk("brx.if_id_flush", IF_ID_flush, 1'b0);
        tick();
        ID_EX_RegWrite  = 1'b0;
        ID_EX_reg_rd    = 4'd0;
        ID_Branch_taken = 1'b0;
        stall_set("brx_after", 1'b0);
        tick();

        // BR R5 with a MEM load to R5
        EX_MEM_reg_rd   = 4'd5;
        EX_MEM_MemToReg = 1'b1;
        stall_set("brm", 1'b1);
        tick();
        EX_MEM_MemToReg = 1'b0;
        stall_set("brm_after", 1'b0);
        tick();

        // BR ignores flags; unrelated register in EX
        ID_SrcReg1     = 4'd6;
        ID_EX_flag_wr  = 1'b1;
        ID_EX_RegWrite = 1'b1;
        ID_EX_reg_rd   = 4'd5;
        stall_set("br_noflag", 1'b0);
        tick();

        // BR R0 with EX writing R0
        ID_SrcReg1    = 4'd0;
        ID_EX_flag_wr = 1'b0;
        ID_EX_reg_rd  = 4'd0;
        stall_set("br_r0", 1'b0);
        tick();

        // flag-setter without a branch in ID
        idle();
        ID_EX_flag_wr = 1'b1;
        stall_set("noflag_br", 1'b0);
        tick();
`ifdef PIPE_PERF_CNT_EN
        chk("pre_hlt.stall_cnt", stall_cnt, 16'd5);
        chk("pre_hlt.flush_cnt", flush_cnt, 16'd1);
`endif

        // HLT: drain 4, halted on the 6th edge
        idle();
        ID_HLT = 1'b1;
        #1;
        chk("hlt.pc_stall",    PC_stall,    1'b1);
        chk("hlt.if_id_flush", IF_ID_flush, 1'b1);
        chk("hlt.id_ex_flush", ID_EX_flush, 1'b0);
        tick();
        load_r3_read_r3();
        for (int e = 1; e <= 5; e++) begin
            #1;
            chk($sformatf("drain%0d.halted", e),      halted,      1'b0);
            chk($sformatf("drain%0d.pc_stall", e),    PC_stall,    1'b1);
            chk($sformatf("drain%0d.if_id_flush", e), IF_ID_flush, 1'b1);
            chk($sformatf("drain%0d.id_ex_flush", e), ID_EX_flush, 1'b0);
            tick();
        end
        #1;
        chk("halt.halted",      halted,      1'b1);
        chk("halt.pc_stall",    PC_stall,    1'b1);
        chk("halt.if_id_flush", IF_ID_flush, 1'b1);
        chk("halt.id_ex_flush", ID_EX_flush, 1'b0);
        ID_Branch_taken = 1'b1;
        repeat (3) tick();
        chk("halt_hold.halted",   halted,   1'b1);
        chk("halt_hold.pc_stall", PC_stall, 1'b1);
`ifdef PIPE_PERF_CNT_EN
        chk("halt.stall_cnt", stall_cnt, 16'd5);
        chk("halt.flush_cnt", flush_cnt, 16'd2);
`endif

        // reset out of HALTED, then reset again mid-DRAIN
        rst_n = 1'b0;
        #2;
        chk("rst_halt.halted", halted, 1'b0);
        idle();
        rst_n = 1'b1;
        tick();
        ID_HLT = 1'b1;
        tick();
        ID_HLT = 1'b0;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_drain.halted",      halted,      1'b0);
        chk("rst_drain.pc_stall",    PC_stall,    1'b0);
        chk("rst_drain.if_id_flush", IF_ID_flush, 1'b0);
`ifdef PIPE_PERF_CNT_EN
        chk("rst_drain.stall_cnt", stall_cnt, 16'd0);
        chk("rst_drain.flush_cnt", flush_cnt, 16'd0);
`endif
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst.pc_stall",    PC_stall,    1'b0);
        chk("post_rst.if_id_flush", IF_ID_flush, 1'b0);
        repeat (8) tick();
        chk("post_rst.halted", halted, 1'b0);
        load_r3_read_r3();
        stall_set("post_rst_lu", 1'b1);
        tick();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL provide parameter DRAIN_CYCLES, default 4, giving the number of cycles the pipeline drains after HLT reaches ID.
REQ-002 SHALL provide these ports, clock and reset first:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ID_SrcReg1  in  4  first source register ID in ID.
- ID_SrcReg2  in  4  second source register ID in ID.
- ID_use1  in  1  ID instruction reads SrcReg1.
- ID_use2  in  1  ID instruction reads SrcReg2.
- ID_Branch  in  1  branch in ID.
- ID_BR  in  1  register-indirect branch in ID.
- ID_Branch_taken  in  1  branch in ID resolves taken.
- ID_HLT  in  1  HLT in ID.
- ID_EX_reg_rd  in  4  destination register in EX.
- ID_EX_RegWrite  in  1  EX instruction writes the register file.
- ID_EX_MemToReg  in  1  EX instruction is a load.
- ID_EX_flag_wr  in  1  EX instruction sets Z/N/V (Z_en | NV_en).
- EX_MEM_reg_rd  in  4  destination register in MEM.
- EX_MEM_MemToReg  in  1  MEM instruction is a load.
- PC_stall  out  1  hold PC.
- IF_ID_stall  out  1  hold the IF/ID register.
- IF_ID_flush  out  1  clear IF/ID to NOP.
- ID_EX_flush  out  1  insert a bubble into ID/EX.
- halted  out  1  processor halted.

Function
REQ-003 SHALL use a registered FSM with states RUN, DRAIN and HALTED, plus a drain counter of width clog2(DRAIN_CYCLES+1).
REQ-004 SHALL raise load_use when ID_EX_MemToReg=1, ID_EX_reg_rd!=0, and ID_EX_reg_rd matches a used ID source (ID_use1/ID_SrcReg1 or ID_use2/ID_SrcReg2).
REQ-005 SHALL raise br_hz when ID_Branch=1 and either:
- ID_BR=1, SrcReg1!=0, and SrcReg1 matches ID_EX_reg_rd with ID_EX_RegWrite=1, or matches EX_MEM_reg_rd with EX_MEM_MemToReg=1; or
- ID_BR=0 and ID_EX_flag_wr=1.
REQ-006 SHALL never raise a hazard on register 0.
REQ-007 In RUN, a hazard (load_use or br_hz) SHALL assert PC_stall, IF_ID_stall and ID_EX_flush in the same cycle (combinational, zero latency); IF_ID_flush=0.
REQ-008 In RUN with no hazard, ID_Branch_taken=1 SHALL assert IF_ID_flush for exactly that cycle.
REQ-009 A hazard SHALL take priority over ID_Branch_taken, because the branch is not yet resolved.
REQ-010 In RUN with no hazard, ID_HLT=1 SHALL load the counter with DRAIN_CYCLES, move the FSM to DRAIN next cycle, and assert PC_stall and IF_ID_flush that cycle.
REQ-011 In DRAIN, the block SHALL:
- hold PC_stall=1 and IF_ID_flush=1;
- decrement the counter each cycle;
- move to HALTED when the counter reaches 0.
REQ-012 ID_EX_flush SHALL be 0 in DRAIN, so in-flight instructions complete.
REQ-013 In HALTED, the block SHALL hold halted=1, PC_stall=1 and IF_ID_flush=1 until reset; all ID inputs are ignored.
REQ-014 halted SHALL be registered and assert the cycle after the counter reaches 0.

Reset
REQ-015 rst_n low SHALL asynchronously force state RUN, counter 0 and halted 0, including when asserted mid-DRAIN.
REQ-016 During reset, all combinational outputs SHALL be 0.

Configuration
REQ-017 With PIPE_PERF_CNT_EN defined, the block SHALL add three outputs:
- stall_cnt (16 bits): counts RUN cycles with a hazard.
- flush_cnt (16 bits): counts IF_ID_flush cycles in RUN.
- cnt_en_n (1 bit): hard-wired 0.
REQ-018 Both counters SHALL saturate at 0xFFFF, freeze in HALTED, and reset to 0.
REQ-019 Without PIPE_PERF_CNT_EN, the counters and their ports SHALL be absent, and all other behaviour is unchanged.

Structure
REQ-020 The FSM state enum and DRAIN_CYCLES default SHALL live in the shared package pipeline_pkg.
REQ-021 The hazard comparison logic SHALL be one sub-module, hazard_detect, which is purely combinational and produces load_use and br_hz.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Load-use: EX is a load to R3; ID reads R3 -> exactly 1 cycle of PC_stall=IF_ID_stall=ID_EX_flush=1, then 0.
- R0 immunity: EX is a load to R0; ID reads R0 -> no stall.
- Branch: EX sets flags, ID holds a conditional taken branch -> stall in cycle 1, IF_ID_flush only in cycle 2.
- BR hazard: ID holds BR R5; EX writes R5 -> stall 1 cycle; with a MEM load to R5 -> stall 1 cycle.
- HLT: HLT in ID with DRAIN_CYCLES=4 -> halted=1 on the 6th edge after the HLT cycle; PC_stall stays high.
- Reset: rst_n low mid-DRAIN -> state RUN and halted=0 immediately; with PIPE_PERF_CNT_EN, the counters read 0.
